video_rx_monitor: RTL and testbench

- Sink-side counterpart of the VGA timing generator: consumes the video interface signals (HS, VS, BLANK, RGB) on pixel_clk.
- Measures the frame geometry, reconstructs pixel coordinates and checks frames against the expected HDISP/VDISP.
- Declares lock after consecutive good frames.
- Used as an on-chip loop-back checker on the video output and as the front end of future capture blocks.

---
 rtl/video_rx_if.sv | 18 +
 rtl/video_rx_monitor.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_video_rx_monitor.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/video_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : video_rx_if
//  Description : Parallel video bus (HS/VS active-low, BLANK high = active
//                pixel, 24-bit RGB). The source drives the master modport,
//                the monitor consumes the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface video_rx_if;
    logic        vid_hs;
    logic        vid_vs;
    logic        vid_blank;
    logic [23:0] vid_rgb;

    modport master (output vid_hs, vid_vs, vid_blank, vid_rgb);
    modport slave  (input  vid_hs, vid_vs, vid_blank, vid_rgb);
endinterface
`default_nettype wire

// File: rtl/video_rx_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : video_rx_monitor
//  Description : Sink-side video timing monitor. Registers the incoming video
//                bus, reconstructs pixel coordinates, measures line/frame
//                geometry, checks every frame against HDISP x VDISP and
//                declares lock after LOCK_FRAMES consecutive good frames.
//                Optional build macro VIDEO_RX_CHECKSUM_EN adds a rotating
//                32-bit checksum over the active pixels of each frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_rx_monitor #(
    parameter int HDISP       = 800,
    parameter int VDISP       = 480,
    parameter int LOCK_FRAMES = 2,
    parameter int CW          = 12
) (
    input  logic          pixel_clk,
    input  logic          sys_rst,
    video_rx_if.slave     vid,
    output logic          pix_valid,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic [23:0]   pix_rgb,
    output logic          frame_start,
    output logic          frame_err,
    output logic          locked,
    output logic [CW-1:0] meas_htotal,
    output logic [CW-1:0] meas_vtotal,
    output logic [CW-1:0] meas_hdisp,
    output logic [CW-1:0] meas_vdisp,
    output logic [31:0]   frame_sum
);

    localparam int            TW       = 2 * CW;
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW:0]   RUN_ONE  = (CW + 1)'(1);
    localparam logic [CW:0]   HDISP_C  = (CW + 1)'(HDISP);
    localparam logic [CW-1:0] VDISP_C  = CW'(VDISP);
    localparam logic [3:0]    LOCK_C   = 4'(LOCK_FRAMES);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } lock_state_t;

    // Counters never wrap: a runaway count must not alias a valid value.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + ONE;
    endfunction

    // ------------------------------------------------------------------------
    // Input stage (s1) and previous-value stage (s2) for edge detection
    // ------------------------------------------------------------------------
    logic        s1_hs, s1_vs, s1_blank;
    logic [23:0] s1_rgb;
    logic        s2_hs, s2_vs, s2_blank;

    logic hs_fall, vs_fall, blank_fall;

    // Register the video pins once, then keep one older copy for edges.
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_blank <= 1'b0;
            s1_rgb   <= '0;
            s2_hs    <= 1'b0;
            s2_vs    <= 1'b0;
            s2_blank <= 1'b0;
        end else begin
            s1_hs    <= vid.vid_hs;
            s1_vs    <= vid.vid_vs;
            s1_blank <= vid.vid_blank;
            s1_rgb   <= vid.vid_rgb;
            s2_hs    <= s1_hs;
            s2_vs    <= s1_vs;
            s2_blank <= s1_blank;
        end
    end

    assign hs_fall    = s2_hs    & ~s1_hs;
    assign vs_fall    = s2_vs    & ~s1_vs;
    assign blank_fall = s2_blank & ~s1_blank;

    // ------------------------------------------------------------------------
    // Pixel output stage: coordinates travel with the data they describe
    // ------------------------------------------------------------------------
    // Second pipeline stage carrying pixel data and reconstructed coordinates.
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pix_valid <= 1'b0;
            pix_rgb   <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
        end else begin
            pix_valid <= s1_blank;
            pix_rgb   <= s1_rgb;
            if (s1_blank) begin
                pix_x <= s2_blank ? sat_inc(pix_x) : '0;
            end
            if (vs_fall) begin
                pix_y <= '0;
            end else if (blank_fall) begin
                pix_y <= sat_inc(pix_y);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Line and frame measurement
    // ------------------------------------------------------------------------
    logic [CW-1:0] h_cnt;        // clocks since the last HS falling edge
    logic          h_seen;       // an HS edge has been seen, h_cnt is a line
    logic [CW-1:0] line_cnt;     // lines closed in the current frame
    logic [CW-1:0] ref_htotal;   // length of the first line of the frame
    logic [CW-1:0] act_cnt;      // active lines in the current frame
    logic [CW-1:0] last_hdisp;   // active width of the latest active line
    logic          frame_bad;
    logic          frame_open;   // a VS edge opened the frame being measured
    logic          verdict_vld;
    logic          verdict_bad;
    logic [TW-1:0] to_cnt;
    logic          timeout;

    logic          line_close;
    logic [CW:0]   run_len;
    logic [CW-1:0] run_sat;
    logic [CW-1:0] line_cnt_nx, ref_nx, act_nx, last_hd_nx;
    logic          bad_nx;
    logic          frame_bad_final;

    // pix_x still holds the last active column when BLANK falls.
    assign run_len    = {1'b0, pix_x} + RUN_ONE;
    assign run_sat    = run_len[CW] ? CNT_MAX : run_len[CW-1:0];
    assign line_close = hs_fall & h_seen;
    assign timeout    = &to_cnt;

    // Fold this cycle's line close and active-line end into the frame state,
    // so a line ending together with VS is counted in the closing frame.
    always_comb begin
        line_cnt_nx = line_cnt;
        ref_nx      = ref_htotal;
        act_nx      = act_cnt;
        last_hd_nx  = last_hdisp;
        bad_nx      = frame_bad;
        if (line_close) begin
            line_cnt_nx = sat_inc(line_cnt);
            if (line_cnt == '0) begin
                ref_nx = h_cnt;
            end else if (h_cnt != ref_htotal) begin
                bad_nx = 1'b1;
            end
        end
        if (blank_fall) begin
            act_nx     = sat_inc(act_cnt);
            last_hd_nx = run_sat;
            if (run_len != HDISP_C) begin
                bad_nx = 1'b1;
            end
        end
        frame_bad_final = bad_nx | (act_nx != VDISP_C);
    end

    // Per-line/per-frame counters, frame verdict and measurement registers.
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            h_cnt       <= '0;
            h_seen      <= 1'b0;
            line_cnt    <= '0;
            ref_htotal  <= '0;
            act_cnt     <= '0;
            last_hdisp  <= '0;
            frame_bad   <= 1'b0;
            frame_open  <= 1'b0;
            verdict_vld <= 1'b0;
            verdict_bad <= 1'b0;
            to_cnt      <= '0;
            frame_start <= 1'b0;
            frame_err   <= 1'b0;
            meas_htotal <= '0;
            meas_vtotal <= '0;
            meas_hdisp  <= '0;
            meas_vdisp  <= '0;
        end else begin
            frame_start <= vs_fall;
            frame_err   <= verdict_vld & verdict_bad;

            if (hs_fall) begin
                h_cnt  <= ONE;
                h_seen <= 1'b1;
            end else begin
                h_cnt <= sat_inc(h_cnt);
            end

            if (vs_fall || timeout) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_ONE;
            end

            if (vs_fall) begin
                // Only a frame that was opened by an earlier VS edge is judged.
                frame_open  <= 1'b1;
                verdict_vld <= frame_open;
                verdict_bad <= frame_bad_final;
                if (frame_open) begin
                    meas_htotal <= ref_nx;
                    meas_vtotal <= line_cnt_nx;
                    meas_hdisp  <= last_hd_nx;
                    meas_vdisp  <= act_nx;
                end
                line_cnt   <= '0;
                ref_htotal <= '0;
                act_cnt    <= '0;
                last_hdisp <= '0;
                frame_bad  <= 1'b0;
            end else if (timeout) begin
                // Signal lost: drop the partial frame, next VS only reopens.
                frame_open  <= 1'b0;
                verdict_vld <= 1'b0;
                line_cnt    <= '0;
                ref_htotal  <= '0;
                act_cnt     <= '0;
                last_hdisp  <= '0;
                frame_bad   <= 1'b0;
            end else begin
                verdict_vld <= 1'b0;
                line_cnt    <= line_cnt_nx;
                ref_htotal  <= ref_nx;
                act_cnt     <= act_nx;
                last_hdisp  <= last_hd_nx;
                frame_bad   <= bad_nx;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------------
    lock_state_t state, state_nx;
    logic [3:0]  good_cnt, good_nx;

    // State register; locked follows the state one cycle later.
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= S_SEARCH;
            good_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            state    <= state_nx;
            good_cnt <= good_nx;
            locked   <= (state == S_LOCKED);
        end
    end

    // Next-state: count consecutive good verdicts, any bad one restarts.
    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        if (timeout) begin
            state_nx = S_SEARCH;
            good_nx  = '0;
        end else if (verdict_vld) begin
            if (verdict_bad) begin
                state_nx = S_SEARCH;
                good_nx  = '0;
            end else begin
                case (state)
                    S_SEARCH: begin
                        good_nx  = 4'd1;
                        state_nx = (LOCK_C <= 4'd1) ? S_LOCKED : S_VERIFY;
                    end
                    S_VERIFY: begin
                        good_nx  = good_cnt + 4'd1;
                        state_nx = ((good_cnt + 4'd1) >= LOCK_C) ? S_LOCKED : S_VERIFY;
                    end
                    S_LOCKED: begin
                        state_nx = S_LOCKED;
                    end
                    default: begin
                        state_nx = S_SEARCH;
                        good_nx  = '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional frame checksum
    // ------------------------------------------------------------------------
`ifdef VIDEO_RX_CHECKSUM_EN
    logic [31:0] sum;

    // Rotate-and-xor accumulator over active pixels, latched per frame.
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sum       <= '0;
            frame_sum <= '0;
        end else if (vs_fall) begin
            if (frame_open) begin
                frame_sum <= sum;
            end
            sum <= '0;
        end else if (timeout) begin
            sum <= '0;
        end else if (s1_blank) begin
            sum <= {sum[30:0], sum[31]} ^ {8'h00, s1_rgb};
        end
    end
`else
    assign frame_sum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_rx_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_rx_monitor
//  Description : Directed bench for video_rx_monitor on a reduced 8x4 raster
//                (12 clocks/line, 6 lines/frame, CW=6 so the signal-loss
//                timeout is 4096 clocks).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_rx_monitor;

    localparam int HD = 8;
    localparam int VD = 4;
    localparam int CW = 6;

    logic          pixel_clk;
    logic          sys_rst;
    logic          pix_valid;
    logic [CW-1:0] pix_x, pix_y;
    logic [23:0]   pix_rgb;
    logic          frame_start, frame_err, locked;
    logic [CW-1:0] meas_htotal, meas_vtotal, meas_hdisp, meas_vdisp;
    logic [31:0]   frame_sum;

    video_rx_if vid ();

    video_rx_monitor #(
        .HDISP(HD), .VDISP(VD), .LOCK_FRAMES(2), .CW(CW)
    ) dut (
        .pixel_clk  (pixel_clk),
        .sys_rst    (sys_rst),
        .vid        (vid),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_rgb    (pix_rgb),
        .frame_start(frame_start),
        .frame_err  (frame_err),
        .locked     (locked),
        .meas_htotal(meas_htotal),
        .meas_vtotal(meas_vtotal),
        .meas_hdisp (meas_hdisp),
        .meas_vdisp (meas_vdisp),
        .frame_sum  (frame_sum)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0, vs_cyc = 0, fs_cyc = 0, fe_cyc = 0, rise_cyc = 0, fall_cyc = 0;
    int n_fs = 0, n_fe = 0;
    logic locked_q = 1'b0;
    logic chk_pix = 1'b0;
    logic [31:0] exp_sum;

    logic        hb0 = 1'b0, hb1 = 1'b0;
    int          hx0 = 0, hx1 = 0, hy0 = 0, hy1 = 0;
    logic [23:0] hr0 = '0, hr1 = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pat(input int x, input int y);
        return {8'(y), 8'(x), 8'hA5};
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_pix"}, 64'({pix_valid, pix_x, pix_y, pix_rgb}), 64'd0);
        chk({tag, "_ctl"}, 64'({frame_start, frame_err, locked, meas_htotal,
                               meas_vtotal, meas_hdisp, meas_vdisp}), 64'd0);
        chk({tag, "_sum"}, 64'(frame_sum), 64'd0);
    endtask

    // One pixel clock: sample outputs (they reflect the pins of two steps ago),
    // record events, then drive the new pin values.
    task automatic step(input logic hs, input logic vs, input logic bl, input int x, input int y);
        logic [23:0] rgb;
        rgb = bl ? pat(x, y) : 24'h0;
        @(negedge pixel_clk);
        cyc++;
        if (frame_start) begin n_fs++; fs_cyc = cyc; end
        if (frame_err)   begin n_fe++; fe_cyc = cyc; end
        if (locked && !locked_q) rise_cyc = cyc;
        if (!locked && locked_q) fall_cyc = cyc;
        locked_q = locked;
        if (chk_pix) begin
            chk("pix_valid", 64'(pix_valid), 64'(hb1));
            if (hb1) begin
                chk("pix_x",   64'(pix_x),   64'(hx1));
                chk("pix_y",   64'(pix_y),   64'(hy1));
                chk("pix_rgb", 64'(pix_rgb), 64'(hr1));
            end
        end
        hb1 = hb0; hx1 = hx0; hy1 = hy0; hr1 = hr0;
        hb0 = bl;  hx0 = x;   hy0 = y;   hr0 = rgb;
        vid.vid_hs    = hs;
        vid.vid_vs    = vs;
        vid.vid_blank = bl;
        vid.vid_rgb   = rgb;
    endtask

    // Raster line: HS low at 0..1, back porch 2, active 3..10, front porch 11.
    // VS is low for the whole of line 4, so VS and HS fall together.
    task automatic gen_frame(input int bad_line, input int rst_line, input logic vs_on);
        for (int ln = 0; ln < 6; ln++) begin
            for (int p = 0; p < 12; p++) begin
                logic act;
                act = (ln < VD) && (p >= 3) && (p <= 10) && !(ln == bad_line && p == 10);
                step(p >= 2, !(vs_on && ln == 4), act, p - 3, ln);
                if (vs_on && ln == 4 && p == 0) vs_cyc = cyc;
                if (ln == rst_line && p == 5) begin
                    #1 sys_rst = 1'b1;
                    #1 reset_checks("async_rst");
                    #1 sys_rst = 1'b0;
                end
            end
        end
    endtask

`ifdef VIDEO_RX_CHECKSUM_EN
    function automatic logic [31:0] model_sum();
        logic [31:0] s;
        s = '0;
        for (int y = 0; y < VD; y++)
            for (int x = 0; x < HD; x++)
                s = {s[30:0], s[31]} ^ {8'h00, pat(x, y)};
        return s;
    endfunction
`endif

    initial begin
`ifdef VIDEO_RX_CHECKSUM_EN
        exp_sum = model_sum();
`else
        exp_sum = 32'h0;
`endif
        sys_rst       = 1'b1;
        vid.vid_hs    = 1'b1;
        vid.vid_vs    = 1'b1;
        vid.vid_blank = 1'b0;
        vid.vid_rgb   = '0;
        repeat (3) @(negedge pixel_clk);
        reset_checks("reset");
        sys_rst = 1'b0;

        // Nominal stream: first VS edge only opens, lock after two verdicts.
        gen_frame(-1, -1, 1'b1);
        chk("open_no_meas", 64'(meas_htotal), 64'd0);
        gen_frame(-1, -1, 1'b1);
        chk("verify_unlocked", 64'(locked), 64'd0);
        chk("meas_htotal", 64'(meas_htotal), 64'd12);
        chk("meas_vtotal", 64'(meas_vtotal), 64'd6);
        chk("meas_hdisp",  64'(meas_hdisp),  64'd8);
        chk("meas_vdisp",  64'(meas_vdisp),  64'd4);
        gen_frame(-1, -1, 1'b1);
        chk("fs_latency",   64'(fs_cyc - vs_cyc),   64'd2);
        chk("lock_latency", 64'(rise_cyc - vs_cyc), 64'd4);
        chk("locked_f2",    64'(locked), 64'd1);
        chk("sum_f2",       64'(frame_sum), 64'(exp_sum));
        gen_frame(-1, -1, 1'b1);
        chk("sum_f3",       64'(frame_sum), 64'(exp_sum));
        chk("no_err_nom",   64'(n_fe), 64'd0);
        chk("fs_count",     64'(n_fs), 64'd4);

        // Last active line of this frame is 7 pixels wide.
        gen_frame(3, -1, 1'b1);
        chk("err_count",    64'(n_fe), 64'd1);
        chk("err_latency",  64'(fe_cyc - vs_cyc), 64'd3);
        chk("unlock_lat",   64'(fall_cyc - vs_cyc), 64'd4);
        chk("unlocked_bad", 64'(locked), 64'd0);
        chk("meas_hd_bad",  64'(meas_hdisp), 64'd7);
        gen_frame(-1, -1, 1'b1);
        chk("relock_f5",    64'(locked), 64'd0);
        gen_frame(-1, -1, 1'b1);
        chk("relock_f6",    64'(locked), 64'd1);

        // Coordinate and data pipeline check over one full frame.
        chk_pix = 1'b1;
        gen_frame(-1, -1, 1'b1);
        chk_pix = 1'b0;

        // Mid-frame reset while locked.
        gen_frame(-1, 2, 1'b1);
        chk("rst_open_meas", 64'(meas_htotal), 64'd0);
        chk("rst_unlocked",  64'(locked), 64'd0);
        chk("rst_no_err",    64'(n_fe), 64'd1);
        gen_frame(-1, -1, 1'b1);
        chk("rst_f9",        64'(locked), 64'd0);
        gen_frame(-1, -1, 1'b1);
        chk("rst_f10",       64'(locked), 64'd1);
        chk("rst_htotal",    64'(meas_htotal), 64'd12);

        // Signal loss: VS stays high past the 4096-clock timeout.
        repeat (3900) step(1'b1, 1'b1, 1'b0, 0, 0);
        chk("pre_timeout",   64'(locked), 64'd1);
        repeat (300) step(1'b1, 1'b1, 1'b0, 0, 0);
        chk("timeout",       64'(locked), 64'd0);
        gen_frame(-1, -1, 1'b1);
        gen_frame(-1, -1, 1'b1);
        chk("to_f12",        64'(locked), 64'd0);
        chk("to_no_err",     64'(n_fe), 64'd1);
        gen_frame(-1, -1, 1'b1);
        chk("to_f13",        64'(locked), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
